// File: rtl/freq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// freq_ctrl_pkg
// Shared types and constants for the frequency sequencer control block.
//   state_t         : FSM state encodings (IDLE/RUN/SWITCH; 2'b11 is illegal)
//   SEL_WIDTH       : width of the divider select bus {select2, select1}
//   DEF_*           : default values for the top-level parameters
// ---------------------------------------------------------------------------
package freq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_SWITCH = 2'b10
    } state_t;

    localparam int SEL_WIDTH           = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
    localparam int DEF_SWEEP_WRAPS     = 4;       // legal range 1..255
    localparam int DEF_DIGIT_MAX       = 9;

endpackage

// File: rtl/frequency_sequencer_ctrl_if.sv
// ---------------------------------------------------------------------------
// frequency_sequencer_ctrl_if
// Connection between the controller and the divider/counter datapath.
//   filtered_clock : divided clock from the datapath (sampled only)
//   count_value    : 4-bit counter Q
//   select1/2      : divider select LSB/MSB
//   counter_enable : counter run gate
//   counter_clear  : one-cycle synchronous clear request
// master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface frequency_sequencer_ctrl_if;
    logic       filtered_clock;
    logic [3:0] count_value;
    logic       select1;
    logic       select2;
    logic       counter_enable;
    logic       counter_clear;

    modport master (
        input  filtered_clock, count_value,
        output select1, select2, counter_enable, counter_clear
    );

    modport slave (
        output filtered_clock, count_value,
        input  select1, select2, counter_enable, counter_clear
    );
endinterface

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Two-flop synchroniser, stability counter and rising-edge press detect for
// one raw push-button.
//   fpga_clock : system clock
//   reset      : asynchronous active-low reset
//   btn_raw    : raw asynchronous button level (active-high)
//   press      : one-cycle pulse when a debounced press is accepted
// A level change is accepted once the synchronised input has disagreed with
// the accepted level for CYCLES consecutive clocks. Input-to-pulse latency is
// 2 (sync) + CYCLES (filter) + 1 (edge detect) clocks.
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int CYCLES = 500000
) (
    input  logic fpga_clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int             CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic             sync0_reg;
    logic             sync1_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge fpga_clock or negedge reset) begin
        if (!reset) begin
            sync0_reg   <= 1'b0;
            sync1_reg   <= 1'b0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            press_reg   <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync0_reg <= btn_raw;
            sync1_reg <= sync0_reg;
            // Any agreement with the accepted level restarts the interval,
            // so a bounce or a release/re-press costs a full new interval.
            if (sync1_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync1_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            level_d_reg <= level_reg;
            press_reg   <= level_reg & ~level_d_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/frequency_sequencer_ctrl.sv
// ---------------------------------------------------------------------------
// frequency_sequencer_ctrl
// Control FSM for the frequency-divider / counter / 7-segment datapath.
//   fpga_clock : system clock (the only clock used here)
//   reset      : asynchronous active-low reset
//   btn_mode   : raw mode button -> advance divider select
//   btn_run    : raw run/pause button -> toggle IDLE/RUN
//   sweep_en   : raw sweep switch -> auto-advance after SWEEP_WRAPS wraps
//   dp         : datapath interface (filtered_clock, count_value in;
//                select1/2, counter_enable, counter_clear out)
//   state_o    : current FSM state (00 IDLE, 01 RUN, 10 SWITCH)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module frequency_sequencer_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SWEEP_WRAPS     = DEF_SWEEP_WRAPS,
    parameter int DIGIT_MAX       = DEF_DIGIT_MAX
) (
    input  logic                        fpga_clock,
    input  logic                        reset,
    input  logic                        btn_mode,
    input  logic                        btn_run,
    input  logic                        sweep_en,
    frequency_sequencer_ctrl_if.master  dp,
    output logic [1:0]                  state_o
);

    localparam logic [7:0] WRAP_LAST  = 8'(SWEEP_WRAPS - 1);
    localparam logic [3:0] DIGIT_LAST = 4'(DIGIT_MAX);

    logic mode_press;
    logic run_press;

    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_deb (
        .fpga_clock (fpga_clock),
        .reset      (reset),
        .btn_raw    (btn_mode),
        .press      (mode_press)
    );

    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_run_deb (
        .fpga_clock (fpga_clock),
        .reset      (reset),
        .btn_raw    (btn_run),
        .press      (run_press)
    );

    logic                 sweep_s0_reg;
    logic                 sweep_s1_reg;
    logic                 fclk_s0_reg;
    logic                 fclk_s1_reg;
    logic                 fclk_prev_reg;
    logic [3:0]           count_prev_reg;
    state_t               state_reg;
    logic [SEL_WIDTH-1:0] sel_reg;
    logic                 enable_reg;
    logic                 clear_reg;
    logic [7:0]           wrap_cnt_reg;

    logic tick;
    logic wrap;
    logic sweep_adv;

    assign tick      = fclk_s1_reg & ~fclk_prev_reg;
    assign wrap      = tick && (count_prev_reg == DIGIT_LAST);
    assign sweep_adv = sweep_s1_reg && (state_reg == ST_RUN) && wrap
                       && (wrap_cnt_reg == WRAP_LAST);

    always_ff @(posedge fpga_clock or negedge reset) begin
        if (!reset) begin
            sweep_s0_reg   <= 1'b0;
            sweep_s1_reg   <= 1'b0;
            fclk_s0_reg    <= 1'b0;
            fclk_s1_reg    <= 1'b0;
            fclk_prev_reg  <= 1'b0;
            count_prev_reg <= '0;
            state_reg      <= ST_IDLE;
            sel_reg        <= '0;
            enable_reg     <= 1'b0;
            clear_reg      <= 1'b0;
            wrap_cnt_reg   <= '0;
        end else begin
            sweep_s0_reg   <= sweep_en;
            sweep_s1_reg   <= sweep_s0_reg;
            fclk_s0_reg    <= dp.filtered_clock;
            fclk_s1_reg    <= fclk_s0_reg;
            fclk_prev_reg  <= fclk_s1_reg;
            count_prev_reg <= dp.count_value;

            // Wrap counter only runs while sweeping in RUN; the SWITCH cycle
            // starts a fresh count for the new frequency.
            if (!sweep_s1_reg || state_reg == ST_SWITCH) begin
                wrap_cnt_reg <= '0;
            end else if (state_reg == ST_RUN && wrap) begin
                wrap_cnt_reg <= (wrap_cnt_reg == WRAP_LAST) ? 8'd0
                                                            : wrap_cnt_reg + 8'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    clear_reg <= 1'b0;
                    if (run_press) begin
                        state_reg  <= ST_RUN;
                        enable_reg <= 1'b1;
                    end else begin
                        enable_reg <= 1'b0;
                        if (mode_press) begin
                            sel_reg   <= sel_reg + 1'b1;
                            clear_reg <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // run_press wins; a coincident mode_press/sweep_adv is
                    // dropped. mode_press and sweep_adv together advance once.
                    if (run_press) begin
                        state_reg  <= ST_IDLE;
                        enable_reg <= 1'b0;
                        clear_reg  <= 1'b0;
                    end else if (mode_press || sweep_adv) begin
                        state_reg  <= ST_SWITCH;
                        sel_reg    <= sel_reg + 1'b1;
                        enable_reg <= 1'b0;
                        clear_reg  <= 1'b1;
                    end else begin
                        enable_reg <= 1'b1;
                        clear_reg  <= 1'b0;
                    end
                end
                ST_SWITCH: begin
                    // Presses landing here are ignored.
                    state_reg  <= ST_RUN;
                    enable_reg <= 1'b1;
                    clear_reg  <= 1'b0;
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    enable_reg <= 1'b0;
                    clear_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign dp.select1        = sel_reg[0];
    assign dp.select2        = sel_reg[1];
    assign dp.counter_enable = enable_reg;
    assign dp.counter_clear  = clear_reg;
    assign state_o           = state_reg;

endmodule

// File: tb/tb_frequency_sequencer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frequency_sequencer_ctrl
// Directed bench with a scoreboard of expected counter_clear events. Each
// stimulus step that should produce a select advance pushes the expected
// {select, state, wraps} entry; the negedge monitor pops and compares when the
// DUT raises counter_clear. A small datapath stand-in drives filtered_clock
// and count_value, and counts wraps independently of the DUT.
// ---------------------------------------------------------------------------
module tb_frequency_sequencer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_run;
    logic       sweep_en;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    frequency_sequencer_ctrl_if dp_if ();

    frequency_sequencer_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .SWEEP_WRAPS     (2),
        .DIGIT_MAX       (9)
    ) dut (
        .fpga_clock (clk),
        .reset      (rst_n),
        .btn_mode   (btn_mode),
        .btn_run    (btn_run),
        .sweep_en   (sweep_en),
        .dp         (dp_if),
        .state_o    (state_o)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] st;
        int         wraps;   // -1: wrap count not checked for this entry
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic       fc_run = 1'b0;
    logic [2:0] div;
    logic [3:0] cnt;
    int         wraps_seen;
    logic [1:0] exp_sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sel_now();
        return {dp_if.select2, dp_if.select1};
    endfunction

    // Monitor + datapath stand-in. filtered_clock has an 8-cycle period; the
    // counter steps on its falling edge so count_value is stable at each rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            div                  = 3'd0;
            cnt                  = 4'd0;
            wraps_seen           = 0;
            dp_if.filtered_clock = 1'b0;
            dp_if.count_value    = 4'd0;
        end else begin
            if (dp_if.counter_clear === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("clear_unexpected", dp_if.counter_clear, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("clear_sel", sel_now(), mon_e.sel);
                    chk("clear_state", state_o, mon_e.st);
                    chk("clear_enable", dp_if.counter_enable, 0);
                    if (mon_e.wraps >= 0)
                        chk("sweep_wraps", wraps_seen, mon_e.wraps);
                end
                wraps_seen = 0;
                cnt        = 4'd0;
            end
            if (fc_run) begin
                div = div + 3'd1;
                if (div == 3'd4 && cnt == 4'd9)
                    wraps_seen++;
                if (div == 3'd0 && dp_if.counter_enable === 1'b1)
                    cnt = (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
            end
            dp_if.filtered_clock = div[2];
            dp_if.count_value    = cnt;
        end
    end

    task automatic press_run();
        btn_run = 1'b1;
        repeat (10) @(negedge clk);
        btn_run = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        repeat (10) @(negedge clk);
        btn_mode = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b1;
        btn_mode = 1'b0;
        btn_run  = 1'b0;
        sweep_en = 1'b0;
        exp_sel  = 2'b00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", state_o, 0);
        chk("rst_sel", sel_now(), 0);
        chk("rst_enable", dp_if.counter_enable, 0);
        chk("rst_clear", dp_if.counter_clear, 0);
        rst_n = 1'b1;

        // Quiet after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("quiet_state", state_o, 0);
            chk("quiet_sel", sel_now(), 0);
            chk("quiet_enable", dp_if.counter_enable, 0);
        end

        // Run press: RUN within 8 cycles of assertion
        btn_run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (state_o == 2'b01) break;
        end
        chk("run_latency_state", state_o, 1);
        chk("run_latency_enable", dp_if.counter_enable, 1);
        repeat (2) @(negedge clk);
        btn_run = 1'b0;
        repeat (12) @(negedge clk);
        press_run();
        chk("pause_state", state_o, 0);
        chk("pause_enable", dp_if.counter_enable, 0);
        press_run();
        chk("rerun_state", state_o, 1);

        // Mode presses in RUN: 01, 10, 11, 00
        for (int k = 0; k < 4; k++) begin
            exp_sel = exp_sel + 2'b01;
            sb_q.push_back('{exp_sel, 2'b10, -1});
            press_mode();
            chk("mode_back_to_run", state_o, 1);
            chk("mode_sel", sel_now(), exp_sel);
            chk("mode_sb_drained", sb_q.size(), 0);
        end

        // Bounce: toggle every 2 cycles for 20 cycles
        for (int i = 0; i < 10; i++) begin
            btn_mode = ~btn_mode;
            repeat (2) @(negedge clk);
        end
        btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_sel", sel_now(), exp_sel);
        chk("bounce_state", state_o, 1);

        // Sweep: two advances, each after 2 wraps
        sweep_en = 1'b1;
        repeat (4) @(negedge clk);
        exp_sel = exp_sel + 2'b01;
        sb_q.push_back('{exp_sel, 2'b10, 2});
        exp_sel = exp_sel + 2'b01;
        sb_q.push_back('{exp_sel, 2'b10, 2});
        fc_run = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        chk("sweep_done", sb_q.size(), 0);
        chk("sweep_sel", sel_now(), 2);
        sweep_en = 1'b0;
        repeat (400) @(negedge clk);
        chk("sweep_off_sel", sel_now(), exp_sel);
        chk("sweep_off_state", state_o, 1);
        fc_run = 1'b0;

        // Same-cycle run + mode in RUN: pause wins, no advance
        btn_run  = 1'b1;
        btn_mode = 1'b1;
        repeat (10) @(negedge clk);
        btn_run  = 1'b0;
        btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        chk("both_state", state_o, 0);
        chk("both_sel", sel_now(), exp_sel);
        chk("both_enable", dp_if.counter_enable, 0);

        // Reset asserted during SWITCH
        press_run();
        chk("pre_switch_state", state_o, 1);
        exp_sel = exp_sel + 2'b01;
        sb_q.push_back('{exp_sel, 2'b10, -1});
        btn_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (state_o == 2'b10) break;
        end
        chk("switch_seen", state_o, 2);
        #2;
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        #1;
        chk("async_rst_state", state_o, 0);
        chk("async_rst_sel", sel_now(), 0);
        chk("async_rst_enable", dp_if.counter_enable, 0);
        chk("async_rst_clear", dp_if.counter_clear, 0);
        exp_sel = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_state", state_o, 0);
        chk("post_rst_sel", sel_now(), exp_sel);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frequency_sequencer_ctrl.md
Name: frequency_sequencer_ctrl

Overview:
- Control block for the frequency-divider / 4-bit counter / 7-segment datapath.
- Turns two raw push-buttons and a sweep switch into the divider's select1/select2 lines, a counter enable and a counter clear.
- Optional auto-sweep mode steps the divider frequency after a set number of 9→0 counter wraps.
- Runs entirely on fpga_clock; the divided clock is only sampled, never used as a clock here.

Parameters:
- DEBOUNCE_CYCLES, 500000, fpga_clock cycles a synchronised button level must stay stable before it is accepted (10 ms at 50 MHz).
- SWEEP_WRAPS, 4, counter wraps per frequency step in sweep mode; legal range 1..255.
- DIGIT_MAX, 9, terminal count of the external counter.

Ports:
- fpga_clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw mode button, asynchronous, active-high.
- btn_run  in  1  raw run/pause button, asynchronous, active-high.
- sweep_en  in  1  raw sweep switch, asynchronous level.
- filtered_clock  in  1  divided clock, sampled only.
- count_value  in  4  counter Q.
- select1  out  1  divider select LSB.
- select2  out  1  divider select MSB.
- counter_enable  out  1  counter run gate.
- counter_clear  out  1  one-cycle synchronous clear request.
- state_o  out  2  current FSM state encoding.

Behaviour:
- Reset (reset=0, asynchronous): select2:select1=00, counter_enable=0, counter_clear=0, state=IDLE, wrap_cnt=0, all synchronisers and debouncers cleared to 0.
- Input conditioning:
  - btn_mode, btn_run, sweep_en and filtered_clock each pass through a 2-flop synchroniser.
  - Each button is debounced; the debounced rising edge gives a one-cycle press pulse.
  - Button-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - A release followed by a re-press needs a full new debounce interval.
- Tick detect: a rising edge of the synchronised filtered_clock gives a one-cycle tick.
- Wrap event: a tick while count_value sampled on the previous cycle == DIGIT_MAX.
- FSM states: IDLE=00, RUN=01, SWITCH=10. 11 is illegal and recovers to IDLE on the next clock.
  - IDLE: counter_enable=0.
    - run_press → RUN.
    - mode_press → advance select, pulse counter_clear for 1 cycle, stay IDLE.
  - RUN: counter_enable=1.
    - run_press → IDLE.
    - mode_press → SWITCH.
    - Sweep advance → SWITCH.
  - SWITCH: lasts exactly 1 cycle.
    - counter_enable=0, counter_clear=1.
    - select advances on entry, so new select values are visible in the SWITCH cycle.
    - wrap_cnt clears.
    - Next state is RUN.
- Select advance: {select2,select1} increments modulo 4 (00→01→10→11→00).
- Sweep:
  - Enabled only when synced sweep_en=1 and state=RUN.
  - Each wrap event increments wrap_cnt.
  - When wrap_cnt reaches SWEEP_WRAPS-1 and a wrap occurs, raise the sweep advance and reset wrap_cnt to 0.
  - sweep_en=0 holds wrap_cnt at 0.
- Priorities within one cycle:
  - run_press beats mode_press and sweep advance; the losers are dropped, not queued.
  - mode_press together with sweep advance gives a single advance.
  - Presses arriving during SWITCH are dropped.
- Outputs are registered; no combinational path from input to output.
- Reset asserted mid-SWITCH returns all outputs to their reset values immediately.

Decomposition:
- Package freq_ctrl_pkg holds:
  - State encodings IDLE/RUN/SWITCH.
  - SEL_WIDTH=2.
  - Default DEBOUNCE_CYCLES, SWEEP_WRAPS and DIGIT_MAX constants.
- One sub-module, button_debouncer (parameter CYCLES), instantiated twice.
  - Contains the synchroniser, the stability counter and the press-pulse edge detect.
- Sweep-switch and tick synchronisers stay inline.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, SWEEP_WRAPS=2.)
- Reset held low, then released → select=00, counter_enable=0, counter_clear=0, state_o=00 for 20 cycles with no stimulus.
- btn_run high 10 cycles → state_o=01 and counter_enable=1 within 8 cycles of assertion; a second press → state_o=00.
- In RUN, btn_mode pressed → one cycle of state_o=10 with counter_clear=1, counter_enable=0 and select=01, then RUN; three more presses → 10, 11, 00.
- Bounce: btn_mode toggles every 2 cycles for 20 cycles, then stays low → no select change.
- Sweep on in RUN, count_value driven 0..9 stepped on filtered_clock edges:
  - After 2 wraps, select 00→01 with a one-cycle counter_clear.
  - After 2 more wraps, select becomes 10.
  - sweep_en=0 → no further change.
- Same-cycle run_press and mode_press in RUN → state_o=00, select unchanged; reset pulsed low during SWITCH → all outputs return to reset values asynchronously.
